lv_power_sequencer: RTL and testbench

Sequences board power and XMC4300 bootstrap for the crate controller's top level. On a software start request it ramps the 3.3 V/2.5 V regulators, straps and releases the XMC4300 out of power-on reset, then enables the masked VP12 regulators one at a time. During operation it watches the LTC2645 open-drain alerts, shuts down on a filtered fault, and performs an orderly shutdown on request. Its registered outputs drive the regulator enables, the XMC JTAG tri-state enable and the XMC PORST_N pin logic. Status is returned to the read-only register map.

---
 rtl/lv_power_sequencer_if.sv | 31 +++
 rtl/lv_power_sequencer.sv | 144 ++++++++++++++
 tb/tb_lv_power_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lv_power_sequencer_if.sv
// lv_power_sequencer_if: request, alert and status signals of the power sequencer
interface lv_power_sequencer_if;
  logic       i_start;
  logic       i_shutdown;
  logic       i_clear_fault;
  logic [5:0] i_vp12_mask;
  logic       i_vp2v5_alert_n;
  logic       i_vp3v3_alert_n;
  logic [5:0] i_vp12_alert_n;
  logic       o_en_3v3;
  logic       o_en_2v5;
  logic [5:0] o_vp12_en;
  logic       o_xmc_jtag_en;
  logic       o_xmc_reset_n;
  logic       o_pwr_good;
  logic       o_fault;
  logic [7:0] o_fault_src;
  logic [3:0] o_state;
  modport master (
    output i_start, i_shutdown, i_clear_fault, i_vp12_mask,
           i_vp2v5_alert_n, i_vp3v3_alert_n, i_vp12_alert_n,
    input  o_en_3v3, o_en_2v5, o_vp12_en, o_xmc_jtag_en, o_xmc_reset_n,
           o_pwr_good, o_fault, o_fault_src, o_state
  );
  modport slave (
    input  i_start, i_shutdown, i_clear_fault, i_vp12_mask,
           i_vp2v5_alert_n, i_vp3v3_alert_n, i_vp12_alert_n,
    output o_en_3v3, o_en_2v5, o_vp12_en, o_xmc_jtag_en, o_xmc_reset_n,
           o_pwr_good, o_fault, o_fault_src, o_state
  );
endinterface

// File: rtl/lv_power_sequencer.sv
// lv_power_sequencer: LV rail ramp, XMC4300 strap/boot, VP12 rail stepping and filtered alert shutdown
module lv_power_sequencer #(
  parameter int LV_SETTLE  = 1_000_000,
  parameter int STRAP_HOLD = 1_000,
  parameter int BOOT_HOLD  = 100_000,
  parameter int RAIL_STEP  = 500_000,
  parameter int FILT       = 16
) (
  input logic clk_axi,
  input logic rst,
  lv_power_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    S_OFF = 4'd0, S_LV_ON = 4'd1, S_STRAP = 4'd2, S_BOOT = 4'd3,
    S_RAIL = 4'd4, S_ON = 4'd5, S_SD = 4'd6, S_FAULT = 4'd7
  } state_t;
  localparam int FW = $clog2(FILT + 1);
  state_t         r_state, w_state_n;
  logic [23:0]    r_cnt, w_cnt_n;
  logic [2:0]     r_idx, w_idx_n;
  logic [5:0]     r_mask, w_mask_n;
  logic [7:0]     r_src, w_src_n;
  logic [7:0]     r_s1, r_s2, w_decl, w_arm, w_hit;
  logic [FW-1:0]  r_fc [8];
  logic           r_en_lv, r_jtag, r_xrst_n, r_pg, r_fault;
  logic [5:0]     r_vp12_en, w_vp12_n, w_upto;
  logic           w_en_lv_n, w_jtag_n, w_xrst_n_n, w_busy, w_lv_arm;
  // Alert bit order {3v3, 2v5, vp12[5:0]} matches fault_src
  always_ff @(posedge clk_axi) begin
    if (rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= {bus.i_vp3v3_alert_n, bus.i_vp2v5_alert_n, bus.i_vp12_alert_n};
      r_s2 <= r_s1;
    end
  end
  always_ff @(posedge clk_axi) begin
    for (int k = 0; k < 8; k++)
      r_fc[k] <= (rst || r_s2[k]) ? '0 : (r_fc[k] == FW'(FILT)) ? r_fc[k] : r_fc[k] + 1'b1;
  end
  always_comb begin
    w_decl = '0;
    for (int k = 0; k < 8; k++) w_decl[k] = r_fc[k] == FW'(FILT);
  end
  assign w_busy   = r_state inside {S_LV_ON, S_STRAP, S_BOOT, S_RAIL, S_ON};
  assign w_lv_arm = r_state inside {S_STRAP, S_BOOT, S_RAIL, S_ON, S_SD};
  assign w_arm    = {{2{w_lv_arm}}, r_vp12_en};
  assign w_hit    = w_decl & w_arm;
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_mask_n  = r_mask;
    w_src_n   = r_src;
    case (r_state)
      S_OFF: if (bus.i_start && !bus.i_shutdown) begin
        w_state_n = S_LV_ON;
        w_cnt_n   = 24'(LV_SETTLE - 1);
        w_mask_n  = bus.i_vp12_mask;
      end
      S_LV_ON: if (r_cnt == '0) begin
        w_state_n = S_STRAP;
        w_cnt_n   = 24'(STRAP_HOLD - 1);
      end else w_cnt_n = r_cnt - 24'd1;
      S_STRAP: if (r_cnt == '0) begin
        w_state_n = S_BOOT;
        w_cnt_n   = 24'(BOOT_HOLD - 1);
      end else w_cnt_n = r_cnt - 24'd1;
      S_BOOT: if (r_cnt == '0) begin
        w_state_n = S_RAIL;
        w_idx_n   = '0;
        w_cnt_n   = 24'(RAIL_STEP - 1);
      end else w_cnt_n = r_cnt - 24'd1;
      // Unmasked rails advance after a single cycle
      S_RAIL: if (!r_mask[r_idx] || r_cnt == '0) begin
        if (r_idx == 3'd5) w_state_n = S_ON;
        else begin
          w_idx_n = r_idx + 3'd1;
          w_cnt_n = 24'(RAIL_STEP - 1);
        end
      end else w_cnt_n = r_cnt - 24'd1;
      S_ON: ;
      S_SD: if (r_cnt == '0) w_state_n = S_OFF;
      else w_cnt_n = r_cnt - 24'd1;
      default: if (bus.i_clear_fault && !(|w_decl)) begin
        w_state_n = S_OFF;
        w_src_n   = '0;
      end
    endcase
    if (bus.i_shutdown && w_busy) begin
      w_state_n = S_SD;
      w_cnt_n   = 24'(RAIL_STEP - 1);
    end
    if (|w_hit) begin
      w_state_n = S_FAULT;
      w_src_n   = w_hit;
    end
  end
  // Outputs are decoded from the next state so they change on the same edge as the state
  always_comb begin
    w_upto     = 6'((7'd2 << w_idx_n) - 7'd1);
    w_en_lv_n  = (w_state_n inside {S_LV_ON, S_STRAP, S_BOOT, S_RAIL, S_ON}) || (w_state_n == S_SD && r_en_lv);
    w_jtag_n   = (w_state_n inside {S_STRAP, S_BOOT}) || (w_state_n == S_SD && r_jtag);
    w_xrst_n_n = (w_state_n inside {S_BOOT, S_RAIL, S_ON}) || (w_state_n == S_SD && r_xrst_n);
    w_vp12_n   = (w_state_n == S_RAIL) ? (w_mask_n & w_upto) : (w_state_n == S_ON) ? w_mask_n : '0;
  end
  always_ff @(posedge clk_axi) begin
    if (rst) begin
      r_state   <= S_OFF;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_mask    <= '0;
      r_src     <= '0;
      r_en_lv   <= 1'b0;
      r_jtag    <= 1'b0;
      r_xrst_n  <= 1'b0;
      r_vp12_en <= '0;
      r_pg      <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_idx     <= w_idx_n;
      r_mask    <= w_mask_n;
      r_src     <= w_src_n;
      r_en_lv   <= w_en_lv_n;
      r_jtag    <= w_jtag_n;
      r_xrst_n  <= w_xrst_n_n;
      r_vp12_en <= w_vp12_n;
      r_pg      <= w_state_n == S_ON;
      r_fault   <= w_state_n == S_FAULT;
    end
  end
  assign bus.o_en_3v3      = r_en_lv;
  assign bus.o_en_2v5      = r_en_lv;
  assign bus.o_vp12_en     = r_vp12_en;
  assign bus.o_xmc_jtag_en = r_jtag;
  assign bus.o_xmc_reset_n = r_xrst_n;
  assign bus.o_pwr_good    = r_pg;
  assign bus.o_fault       = r_fault;
  assign bus.o_fault_src   = r_src;
  assign bus.o_state       = r_state;
endmodule

// File: tb/tb_lv_power_sequencer.sv
// tb_lv_power_sequencer: table-driven and directed checks of the power sequencer
module tb_lv_power_sequencer;
  logic clk_axi = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  lv_power_sequencer_if bus ();
  lv_power_sequencer #(
    .LV_SETTLE(10), .STRAP_HOLD(4), .BOOT_HOLD(8), .RAIL_STEP(5), .FILT(3)
  ) dut (
    .clk_axi(clk_axi),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk_axi = ~clk_axi;
  typedef struct {
    int          n;
    logic        st;
    logic        sd;
    logic        cl;
    logic [5:0]  mask;
    logic [7:0]  pins;
    logic [23:0] exp;
    string       nm;
  } tv_t;
  tv_t tv [25];
  logic [23:0] act;
  assign act = {bus.o_en_3v3, bus.o_en_2v5, bus.o_xmc_jtag_en, bus.o_xmc_reset_n, bus.o_vp12_en,
                bus.o_pwr_good, bus.o_fault, bus.o_fault_src, bus.o_state};
  function automatic logic [23:0] ex(input logic en, input logic jtag, input logic xrst,
                                     input logic [5:0] vp, input logic pg, input logic flt,
                                     input logic [7:0] src, input logic [3:0] st);
    return {en, en, jtag, xrst, vp, pg, flt, src, st};
  endfunction
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_axi);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [23:0] e);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got en/jtag/xrst/vp12/pg/flt/src/st=%h required %h", nm, act, e);
    end
  endtask
  task automatic set_pins(input logic [7:0] p);
    bus.i_vp3v3_alert_n = p[7];
    bus.i_vp2v5_alert_n = p[6];
    bus.i_vp12_alert_n  = p[5:0];
  endtask
  task automatic pulse_start(input logic [5:0] m);
    bus.i_vp12_mask = m;
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_shutdown = 1'b0;
    bus.i_clear_fault = 1'b0;
    set_pins(8'hFF);
    step(2);
    rst = 1'b0;
  endtask
  task automatic run(input tv_t v);
    bus.i_vp12_mask   = v.mask;
    set_pins(v.pins);
    bus.i_start       = v.st;
    bus.i_shutdown    = v.sd;
    bus.i_clear_fault = v.cl;
    step(1);
    bus.i_start       = 1'b0;
    bus.i_shutdown    = 1'b0;
    bus.i_clear_fault = 1'b0;
    step(v.n - 1);
    chk(v.nm, v.exp);
  endtask
  initial begin
    tv[0]  = '{1,  0, 0, 0, 6'h05, 8'hFF, ex(0,0,0,6'h00,0,0,8'h00,4'd0), "idle"};
    tv[1]  = '{1,  1, 0, 0, 6'h05, 8'hFF, ex(1,0,0,6'h00,0,0,8'h00,4'd1), "lv_on_e1"};
    tv[2]  = '{9,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,0,6'h00,0,0,8'h00,4'd1), "lv_dwell_e10"};
    tv[3]  = '{1,  0, 0, 0, 6'h05, 8'hFF, ex(1,1,0,6'h00,0,0,8'h00,4'd2), "strap_e11"};
    tv[4]  = '{3,  0, 0, 0, 6'h05, 8'hFF, ex(1,1,0,6'h00,0,0,8'h00,4'd2), "strap_e14"};
    tv[5]  = '{1,  0, 0, 0, 6'h05, 8'hFF, ex(1,1,1,6'h00,0,0,8'h00,4'd3), "boot_e15"};
    tv[6]  = '{7,  0, 0, 0, 6'h05, 8'hFF, ex(1,1,1,6'h00,0,0,8'h00,4'd3), "boot_e22"};
    tv[7]  = '{1,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h01,0,0,8'h00,4'd4), "rail0_e23"};
    tv[8]  = '{5,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h01,0,0,8'h00,4'd4), "rail1_e28"};
    tv[9]  = '{1,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h05,0,0,8'h00,4'd4), "rail2_e29"};
    tv[10] = '{7,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h05,0,0,8'h00,4'd4), "rail5_e36"};
    tv[11] = '{1,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h05,1,0,8'h00,4'd5), "on_e37"};
    tv[12] = '{3,  1, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h05,1,0,8'h00,4'd5), "start_in_on"};
    tv[13] = '{1,  0, 1, 0, 6'h05, 8'hFF, ex(1,0,1,6'h00,0,0,8'h00,4'd6), "sd_entry"};
    tv[14] = '{4,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h00,0,0,8'h00,4'd6), "sd_dwell"};
    tv[15] = '{1,  0, 0, 0, 6'h05, 8'hFF, ex(0,0,0,6'h00,0,0,8'h00,4'd0), "sd_off"};
    tv[16] = '{2,  1, 1, 0, 6'h05, 8'hFF, ex(0,0,0,6'h00,0,0,8'h00,4'd0), "collide_off"};
    tv[17] = '{37, 1, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h05,1,0,8'h00,4'd5), "reup_on"};
    tv[18] = '{2,  0, 0, 0, 6'h05, 8'hFE, ex(1,0,1,6'h05,1,0,8'h00,4'd5), "glitch_low"};
    tv[19] = '{8,  0, 0, 0, 6'h05, 8'hFF, ex(1,0,1,6'h05,1,0,8'h00,4'd5), "glitch_no_fault"};
    tv[20] = '{5,  0, 0, 0, 6'h05, 8'hFE, ex(1,0,1,6'h05,1,0,8'h00,4'd5), "alert_e5"};
    tv[21] = '{1,  0, 0, 0, 6'h05, 8'hFE, ex(0,0,0,6'h00,0,1,8'h01,4'd7), "alert_fault_e6"};
    tv[22] = '{3,  0, 0, 1, 6'h05, 8'hFE, ex(0,0,0,6'h00,0,1,8'h01,4'd7), "clr_ignored"};
    tv[23] = '{5,  0, 0, 0, 6'h05, 8'hFF, ex(0,0,0,6'h00,0,1,8'h01,4'd7), "alert_released"};
    tv[24] = '{1,  0, 0, 1, 6'h05, 8'hFF, ex(0,0,0,6'h00,0,0,8'h00,4'd0), "clr_ok"};
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_shutdown = 1'b0;
    bus.i_clear_fault = 1'b0;
    bus.i_vp12_mask = 6'h00;
    set_pins(8'hFF);
    step(3);
    chk("reset", ex(0,0,0,6'h00,0,0,8'h00,4'd0));
    rst = 1'b0;
    foreach (tv[i]) run(tv[i]);
    do_reset();
    set_pins(8'hFD);
    pulse_start(6'h05);
    step(36);
    chk("vp12_1_unarmed_on", ex(1,0,1,6'h05,1,0,8'h00,4'd5));
    do_reset();
    set_pins(8'h7F);
    pulse_start(6'h05);
    step(9);
    chk("3v3_unarmed_lv_on", ex(1,0,0,6'h00,0,0,8'h00,4'd1));
    step(1);
    chk("3v3_armed_strap", ex(1,1,0,6'h00,0,0,8'h00,4'd2));
    step(1);
    chk("3v3_fault", ex(0,0,0,6'h00,0,1,8'h80,4'd7));
    do_reset();
    pulse_start(6'h05);
    step(15);
    chk("pre_rst_boot", ex(1,1,1,6'h00,0,0,8'h00,4'd3));
    rst = 1'b1;
    step(1);
    chk("mid_rst", ex(0,0,0,6'h00,0,0,8'h00,4'd0));
    rst = 1'b0;
    pulse_start(6'h05);
    chk("rerun_e1", ex(1,0,0,6'h00,0,0,8'h00,4'd1));
    step(10);
    chk("rerun_e11", ex(1,1,0,6'h00,0,0,8'h00,4'd2));
    step(4);
    chk("rerun_e15", ex(1,1,1,6'h00,0,0,8'h00,4'd3));
    step(8);
    chk("rerun_e23", ex(1,0,1,6'h01,0,0,8'h00,4'd4));
    step(14);
    chk("rerun_e37", ex(1,0,1,6'h05,1,0,8'h00,4'd5));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
